alu_flags: RTL and testbench

ALU_FLAGS -- requirements
Module: alu_flags

---
 rtl/alu_flags.sv | 152 +++++++++++++++
 tb/tb_alu_flags.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_flags                                                     |
// | Purpose  : Z/N/H/C flag register for a nibble-serial ALU. A low-nibble   |
// |            pass is captured as pending partial flags and a high pass     |
// |            commits the architectural flags. Direct F writes (POP AF)     |
// |            override the ALU.                                             |
// | Option   : ALU_FLAGS_DAA_EN adds the acc input and the daa_adj/daa_c     |
// |            outputs, a decimal-adjust correction derived from N/H/C.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_flags (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       l,
  input  logic       h,
  input  logic       nib_zero,
  input  logic       nib_co,
  input  logic       shift_dbh,
  input  logic       ld_z,
  input  logic       ld_n,
  input  logic       ld_h,
  input  logic       ld_c,
  input  logic       n_val,
  input  logic [1:0] c_sel,
  input  logic [1:0] h_sel,
  input  logic       fl_we,
  input  logic [7:0] fl_din,
`ifdef ALU_FLAGS_DAA_EN
  input  logic [7:0] acc,
  output logic [7:0] daa_adj,
  output logic       daa_c,
`endif
  output logic [7:0] fl,
  output logic       alu_ci,
  output logic       pend
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LOW_DONE = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   z_q, z_d;
  logic   n_q, n_d;
  logic   h_q, h_d;
  logic   c_q, c_d;
  logic   z_lo_q, z_lo_d;
  logic   h_lo_q, h_lo_d;

  // The low nibble of a direct F write has no storage behind it.
  logic   unused_fl_din_lo;
  assign unused_fl_din_lo = ^fl_din[3:0];

  // Flag and pass-state registers; idle values of z_lo/h_lo make a lone high pass self-contained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      h_q     <= 1'b0;
      c_q     <= 1'b0;
      z_lo_q  <= 1'b1;
      h_lo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      n_q     <= n_d;
      h_q     <= h_d;
      c_q     <= c_d;
      z_lo_q  <= z_lo_d;
      h_lo_q  <= h_lo_d;
    end
  end

  // Next-state: direct write beats the ALU; low pass captures, high or full pass commits.
  always_comb begin
    logic z_src;
    logic h_src;
    state_d = state_q;
    z_d     = z_q;
    n_d     = n_q;
    h_d     = h_q;
    c_d     = c_q;
    z_lo_d  = z_lo_q;
    h_lo_d  = h_lo_q;
    // A full pass (l&h) sees the whole byte now; a high pass merges the captured low half.
    z_src   = l ? nib_zero : (z_lo_q & nib_zero);
    h_src   = l ? nib_co   : h_lo_q;

    if (fl_we) begin
      z_d     = fl_din[7];
      n_d     = fl_din[6];
      h_d     = fl_din[5];
      c_d     = fl_din[4];
      z_lo_d  = 1'b1;
      h_lo_d  = 1'b0;
      state_d = IDLE;
    end else if (ce && l && !h) begin
      z_lo_d  = nib_zero;
      h_lo_d  = nib_co;
      state_d = LOW_DONE;
    end else if (ce && h) begin
      if (ld_z) z_d = z_src;
      if (ld_n) n_d = n_val;
      if (ld_h) begin
        case (h_sel)
          2'd0:    h_d = h_src;
          2'd3:    h_d = 1'b1;
          default: h_d = 1'b0;   // 1 is reserved and behaves as force-0
        endcase
      end
      if (ld_c) begin
        case (c_sel)
          2'd0:    c_d = nib_co;
          2'd1:    c_d = shift_dbh;
          2'd2:    c_d = 1'b0;
          default: c_d = 1'b1;
        endcase
      end
      z_lo_d  = 1'b1;
      h_lo_d  = 1'b0;
      state_d = IDLE;
    end
  end

  assign fl     = {z_q, n_q, h_q, c_q, 4'b0000};
  assign alu_ci = c_q;
  assign pend   = (state_q == LOW_DONE);

`ifdef ALU_FLAGS_DAA_EN
  // Decimal-adjust correction: add after addition, subtract after subtraction.
  always_comb begin
    daa_adj = 8'h00;
    daa_c   = 1'b0;
    if (!n_q) begin
      if (h_q || (acc[3:0] > 4'd9)) daa_adj[3:0] = 4'h6;
      if (c_q || (acc > 8'h99)) begin
        daa_adj[7:4] = 4'h6;
        daa_c        = 1'b1;
      end
    end else begin
      daa_adj = {(c_q ? 4'h6 : 4'h0), (h_q ? 4'h6 : 4'h0)};
      daa_c   = c_q;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_flags                                                  |
// | Purpose  : Directed self-checking bench for alu_flags with an expected-  |
// |            value queue popped one cycle after each driven step.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_flags;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0, l = 1'b0, h = 1'b0;
  logic       nib_zero = 1'b0, nib_co = 1'b0, shift_dbh = 1'b0;
  logic       ld_z = 1'b0, ld_n = 1'b0, ld_h = 1'b0, ld_c = 1'b0;
  logic       n_val = 1'b0;
  logic [1:0] c_sel = 2'd0, h_sel = 2'd0;
  logic       fl_we = 1'b0;
  logic [7:0] fl_din = 8'h00;
  logic [7:0] fl;
  logic       alu_ci, pend;
`ifdef ALU_FLAGS_DAA_EN
  logic [7:0] acc = 8'h00;
  logic [7:0] daa_adj;
  logic       daa_c;
`endif

  typedef struct packed {
    logic [7:0] fl;
    logic       pend;
    logic       ci;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  alu_flags dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .l         (l),
    .h         (h),
    .nib_zero  (nib_zero),
    .nib_co    (nib_co),
    .shift_dbh (shift_dbh),
    .ld_z      (ld_z),
    .ld_n      (ld_n),
    .ld_h      (ld_h),
    .ld_c      (ld_c),
    .n_val     (n_val),
    .c_sel     (c_sel),
    .h_sel     (h_sel),
    .fl_we     (fl_we),
    .fl_din    (fl_din),
`ifdef ALU_FLAGS_DAA_EN
    .acc       (acc),
    .daa_adj   (daa_adj),
    .daa_c     (daa_c),
`endif
    .fl        (fl),
    .alu_ci    (alu_ci),
    .pend      (pend)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".fl"},     fl,              e.fl);
    check({tag, ".pend"},   {7'd0, pend},    {7'd0, e.pend});
    check({tag, ".alu_ci"}, {7'd0, alu_ci},  {7'd0, e.ci});
  endtask

  // Drive one cycle of inputs, queue the expected outputs, clock, then pop and compare.
  task automatic step(input logic i_ce, input logic i_l, input logic i_h,
                      input logic nz, input logic nco, input logic sh,
                      input logic [3:0] ld, input logic nv,
                      input logic [1:0] cs, input logic [1:0] hs,
                      input logic we, input logic [7:0] din,
                      input logic [7:0] e_fl, input logic e_pend, input logic e_ci,
                      input string tag);
    exp_t  e;
    string t;
    ce = i_ce; l = i_l; h = i_h;
    nib_zero = nz; nib_co = nco; shift_dbh = sh;
    {ld_z, ld_n, ld_h, ld_c} = ld;
    n_val = nv; c_sel = cs; h_sel = hs;
    fl_we = we; fl_din = din;
    exp_q.push_back('{fl: e_fl, pend: e_pend, ci: e_ci});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    ce = 1'b0; l = 1'b0; h = 1'b0; fl_we = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_outputs(t, e);
  endtask

  initial begin
    exp_t e;
    // Asynchronous reset between clock edges.
    #1 reset = 1'b1;
    #1;
    e = '{fl: 8'h00, pend: 1'b0, ci: 1'b0};
    check_outputs("reset", e);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    //   ce  l  h  nz nco sh ld     nv cs hs we din    fl     pd ci
    // RLC 0x80
    step(1, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, "rlc_lo");
    step(1, 0, 1, 0, 0, 1, 4'hF, 0, 1, 2, 0, 8'h00, 8'h10, 0, 1, "rlc_hi");
    // ADD 0x0F+0x01: half carry from the low pass
    step(1, 1, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h10, 1, 1, "add0f_lo");
    step(1, 0, 1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 8'h00, 8'h20, 0, 0, "add0f_hi");
    // ADD 0x80+0x80: zero result with carry
    step(1, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h20, 1, 0, "add80_lo");
    step(1, 0, 1, 1, 1, 0, 4'hF, 0, 0, 0, 0, 8'h00, 8'h90, 0, 1, "add80_hi");
    // No-op cycles: ce=0, then l=h=0
    step(0, 0, 1, 1, 0, 0, 4'hF, 1, 2, 3, 0, 8'h00, 8'h90, 0, 1, "ce_off");
    step(1, 0, 0, 1, 0, 0, 4'hF, 1, 2, 3, 0, 8'h00, 8'h90, 0, 1, "no_pass");
    // Repeated low pass overwrites the captured values
    step(1, 1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h90, 1, 1, "lo_first");
    step(1, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h90, 1, 1, "lo_again");
    step(1, 0, 1, 1, 1, 0, 4'hF, 1, 2, 0, 0, 8'h00, 8'hC0, 0, 0, "hi_after_rep");
    // Per-flag enables: only N loads
    step(1, 0, 1, 0, 1, 1, 4'h4, 0, 3, 3, 0, 8'h00, 8'h80, 0, 0, "ld_n_only");
    // High pass from IDLE: Z from nib_zero alone, H from idle h_lo=0
    step(1, 0, 1, 0, 1, 0, 4'hF, 0, 3, 0, 0, 8'h00, 8'h10, 0, 1, "hi_from_idle");
    // Single-cycle full pass
    step(1, 1, 1, 1, 1, 0, 4'hF, 1, 0, 0, 0, 8'h00, 8'hF0, 0, 1, "full_pass");
    // Reserved h_sel clears H
    step(1, 0, 1, 0, 0, 0, 4'h2, 0, 0, 1, 0, 8'h00, 8'hD0, 0, 1, "hsel_rsvd");
    // Direct write ignores low nibble
    step(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h0F, 8'h00, 0, 0, "we_lownib");
    // Direct write beats a simultaneous high pass and clears pending
    step(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, "pre_we_lo");
    step(1, 0, 1, 0, 0, 0, 4'hF, 1, 2, 2, 1, 8'hFF, 8'hF0, 0, 1, "we_vs_hi");
    // Direct write beats a low pass: stays IDLE
    step(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h5A, 8'h50, 0, 1, "we_vs_lo");
    // Reset abandons a pending low pass
    step(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h50, 1, 1, "pre_rst_lo");
    reset = 1'b1;
    #1;
    e = '{fl: 8'h00, pend: 1'b0, ci: 1'b0};
    check_outputs("rst_in_pend", e);
    #2 reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, "post_rst_idle");
    step(1, 0, 1, 1, 0, 0, 4'h8, 0, 0, 0, 0, 8'h00, 8'h80, 0, 0, "post_rst_hi");

`ifdef ALU_FLAGS_DAA_EN
    step(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, "daa_clr");
    acc = 8'h9A;
    #1;
    check("daa_add.adj", daa_adj, 8'h66);
    check("daa_add.c",   {7'd0, daa_c}, 8'h01);
    step(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h50, 8'h50, 0, 1, "daa_sub_set");
    acc = 8'h00;
    #1;
    check("daa_sub.adj", daa_adj, 8'h60);
    check("daa_sub.c",   {7'd0, daa_c}, 8'h01);
`endif

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
